// File: rtl/apb_reg_slave.sv
`timescale 1ns/1ps
// apb_reg_slave: APB completer feeding the 8-entry register file write port,
// with wait states, byte-strobe merge, address decode and error response.
module apb_reg_slave #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int REG_NUM = 8,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_CYCLES = 0,
  parameter logic [7:0] RO_MASK = 8'h00
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [APB_DATA_WIDTH-1:0]   PWDATA,
  input  logic [APB_DATA_WIDTH/8-1:0] PSTRB,
  output logic                        PREADY,
  output logic [APB_DATA_WIDTH-1:0]   PRDATA,
  output logic                        PSLVERR,
  output logic                        reg_apb_wen,
  output logic [APB_DATA_WIDTH-1:0]   reg_apb_wdata,
  output logic [2:0]                  reg_apb_addr,
  input  logic [APB_DATA_WIDTH-1:0]   R0,
  input  logic [APB_DATA_WIDTH-1:0]   R1,
  input  logic [APB_DATA_WIDTH-1:0]   R2,
  input  logic [APB_DATA_WIDTH-1:0]   R3,
  input  logic [APB_DATA_WIDTH-1:0]   R4,
  input  logic [APB_DATA_WIDTH-1:0]   R5,
  input  logic [APB_DATA_WIDTH-1:0]   R6,
  input  logic [APB_DATA_WIDTH-1:0]   R7
);

  localparam int NB = APB_DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [3:0]                  r_wait_cnt;
  logic [APB_ADDR_WIDTH-1:0]   r_addr_q;
  logic                        r_write_q;

  logic                        w_setup;
  logic                        w_busq;
  logic [APB_ADDR_WIDTH-1:0]   w_off;
  logic [2:0]                  w_idx;
  logic                        w_err_addr;
  logic                        w_err_ro;
  logic [APB_DATA_WIDTH-1:0]   w_cur;
  logic [APB_DATA_WIDTH-1:0]   w_regs [REG_NUM];

  assign w_setup = PSEL & ~PENABLE;
  assign w_busq  = PSEL & PENABLE;

  assign w_regs[0] = R0;
  assign w_regs[1] = R1;
  assign w_regs[2] = R2;
  assign w_regs[3] = R3;
  assign w_regs[4] = R4;
  assign w_regs[5] = R5;
  assign w_regs[6] = R6;
  assign w_regs[7] = R7;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr_q   <= '0;
      r_write_q  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_setup) begin
        r_wait_cnt <= 4'(WAIT_CYCLES);
        r_addr_q   <= PADDR;
        r_write_q  <= PWRITE;
      end else if (r_state == S_ACCESS && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // A dropped PSEL/PENABLE in ACCESS abandons the transfer silently.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_setup) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (!w_busq || r_wait_cnt == '0) w_next = S_IDLE;
      end
    endcase
  end

  assign w_off      = r_addr_q - BASE_ADDR;
  assign w_idx      = w_off[4:2];
  assign w_err_addr = (r_addr_q < BASE_ADDR)
                    | (w_off >= APB_ADDR_WIDTH'(32));
  assign w_err_ro   = r_write_q & RO_MASK[w_idx] & ~w_err_addr;
  assign w_cur      = w_regs[w_idx];

  always_comb begin
    PREADY        = (r_state == S_ACCESS)
                  & (r_wait_cnt == '0) & w_busq;
    PSLVERR       = PREADY & (w_err_addr | w_err_ro);
    reg_apb_wen   = PREADY & r_write_q & ~PSLVERR
                  & (PSTRB != '0);
    reg_apb_addr  = w_idx;
    PRDATA        = '0;
    if (PREADY && !r_write_q && !w_err_addr) PRDATA = w_cur;
    reg_apb_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      reg_apb_wdata[8*b +: 8] = PSTRB[b] ? PWDATA[8*b +: 8]
                                         : w_cur[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
`timescale 1ns/1ps
// tb_apb_reg_slave: two completers (0 and 3 wait states) with a
// register-file model; expected responses are queued and checked by a monitor.
module tb_apb_reg_slave;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        err;
    logic        wen;
    logic [2:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn   [2];
  logic        psel   [2];
  logic        pen    [2];
  logic        pwr    [2];
  logic [15:0] paddr  [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb  [2];
  logic        pready [2];
  logic        pslverr[2];
  logic        wen    [2];
  logic [31:0] prdata [2];
  logic [31:0] wdata  [2];
  logic [2:0]  waddr  [2];

  logic [31:0] rf0 [8];
  logic [31:0] rf1 [8];

  logic        bd_en;
  int          bd_d;
  logic [2:0]  bd_i;
  logic [31:0] bd_v;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  done  = 1'b0;

  always @(posedge clk) begin
    if (wen[0]) rf0[waddr[0]] <= wdata[0];
    else if (bd_en && bd_d == 0) rf0[bd_i] <= bd_v;
    if (wen[1]) rf1[waddr[1]] <= wdata[1];
    else if (bd_en && bd_d == 1) rf1[bd_i] <= bd_v;
  end

  apb_reg_slave #(.WAIT_CYCLES(0), .RO_MASK(8'h02)) u_dut0 (
    .clk(clk), .resetn(rstn[0]),
    .PSEL(psel[0]), .PENABLE(pen[0]), .PWRITE(pwr[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .reg_apb_wen(wen[0]), .reg_apb_wdata(wdata[0]),
    .reg_apb_addr(waddr[0]),
    .R0(rf0[0]), .R1(rf0[1]), .R2(rf0[2]), .R3(rf0[3]),
    .R4(rf0[4]), .R5(rf0[5]), .R6(rf0[6]), .R7(rf0[7])
  );

  apb_reg_slave #(.WAIT_CYCLES(3), .RO_MASK(8'h02)) u_dut3 (
    .clk(clk), .resetn(rstn[1]),
    .PSEL(psel[1]), .PENABLE(pen[1]), .PWRITE(pwr[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
    .reg_apb_wen(wen[1]), .reg_apb_wdata(wdata[1]),
    .reg_apb_addr(waddr[1]),
    .R0(rf1[0]), .R1(rf1[1]), .R2(rf1[2]), .R3(rf1[3]),
    .R4(rf1[4]), .R5(rf1[5]), .R6(rf1[6]), .R7(rf1[7])
  );

  task automatic chk(input string nm, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, required %h", nm, d, act, exp);
    end
  endtask

  task automatic preload(input int d, input logic [2:0] i,
                         input logic [31:0] v);
    bd_d = d; bd_i = i; bd_v = v; bd_en = 1'b1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // Starts at posedge+1; returns at posedge+1 after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input int ew, input logic [31:0] er, input logic ee,
                      input logic ewen, input logic [2:0] ea,
                      input logic [31:0] ewd);
    exp_t e;
    bit   got;
    e = '{ew, er, ee, ewen, ea, ewd};
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    pen[d] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = pready[d];
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout dut%0d addr=%h: no PREADY, required within 20",
               d, a);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; pen[d] = 1'b0;
  endtask

  task automatic monitor();
    int   acc [2];
    exp_t e;
    int   qs;
    acc[0] = 0;
    acc[1] = 0;
    while (!done) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (pready[d] === 1'b1) begin
          qs = (d == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pready dut%0d: got 1, required 0", d);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("wait_cycles", d, 32'(acc[d]), 32'(e.waits));
            chk("prdata", d, prdata[d], e.rdata);
            chk("pslverr", d, 32'(pslverr[d]), 32'(e.err));
            chk("wen", d, 32'(wen[d]), 32'(e.wen));
            if (e.wen) begin
              chk("waddr", d, 32'(waddr[d]), 32'(e.waddr));
              chk("wdata", d, wdata[d], e.wdata);
            end
          end
          acc[d] = 0;
        end else begin
          n_cmp++;
          if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0 ||
              wen[d] !== 1'b0) begin
            n_err++;
            $display("FAIL idle_quiet dut%0d: prdata=%h slverr=%b wen=%b, required 0/0/0",
                     d, prdata[d], pslverr[d], wen[d]);
          end
          if (psel[d] && pen[d]) acc[d]++;
          else if (!psel[d])     acc[d] = 0;
        end
      end
    end
  endtask

  task automatic stim();
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready", 0, 32'(pready[0]), 32'h0);
    chk("rst_pready", 1, 32'(pready[1]), 32'h0);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    @(posedge clk); #1;
    preload(0, 3'd3, 32'h11223344);
    preload(0, 3'd1, 32'hCAFEF00D);
    preload(0, 3'd6, 32'h66666666);
    preload(1, 3'd7, 32'h00000077);

    // zero wait states
    xfer(0, 1, 16'h0008, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1, 3'd2, 32'hDEADBEEF);
    xfer(0, 1, 16'h000C, 32'hAABBCCDD, 4'h5, 0, 0, 0, 1, 3'd3, 32'h11BB33DD);
    xfer(0, 1, 16'h0004, 32'h12345678, 4'hF, 0, 0, 1, 0, 3'd0, 32'h0);
    xfer(0, 0, 16'h0020, 32'h0, 4'hF, 0, 32'h0, 1, 0, 3'd0, 32'h0);
    xfer(0, 0, 16'h0004, 32'h0, 4'hF, 0, 32'hCAFEF00D, 0, 0, 3'd0, 32'h0);
    xfer(0, 1, 16'h0014, 32'h12345678, 4'hF, 0, 0, 0, 1, 3'd5, 32'h12345678);
    xfer(0, 0, 16'h0014, 32'h0, 4'hF, 0, 32'h12345678, 0, 0, 3'd0, 32'h0);
    xfer(0, 1, 16'h0018, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, 3'd0, 32'h0);
    xfer(0, 0, 16'h0018, 32'h0, 4'hF, 0, 32'h66666666, 0, 0, 3'd0, 32'h0);
    xfer(0, 1, 16'h000B, 32'h99000000, 4'h8, 0, 0, 0, 1, 3'd2, 32'h99ADBEEF);
    xfer(0, 0, 16'h0008, 32'h0, 4'hF, 0, 32'h99ADBEEF, 0, 0, 3'd0, 32'h0);
    xfer(0, 0, 16'h000C, 32'h0, 4'hF, 0, 32'h11BB33DD, 0, 0, 3'd0, 32'h0);
    xfer(0, 0, 16'hFFFC, 32'h0, 4'hF, 0, 32'h0, 1, 0, 3'd0, 32'h0);

    // three wait states
    xfer(1, 0, 16'h001C, 32'h0, 4'hF, 3, 32'h00000077, 0, 0, 3'd0, 32'h0);
    xfer(1, 1, 16'h0010, 32'hA5A5A5A5, 4'hF, 3, 0, 0, 1, 3'd4, 32'hA5A5A5A5);

    // abort: PSEL dropped after one wait cycle
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1;
    paddr[1] = 16'h0010; pwdata[1] = 32'h0; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; pen[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // reset pulse during a wait state
    psel[1] = 1'b1; pen[1] = 1'b0; pwr[1] = 1'b1;
    paddr[1] = 16'h0010; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    pen[1] = 1'b1;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    @(negedge clk);
    chk("rst_mid_pready", 1, 32'(pready[1]), 32'h0);
    @(posedge clk); #1;
    psel[1] = 1'b0; pen[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    xfer(1, 0, 16'h0010, 32'h0, 4'hF, 3, 32'hA5A5A5A5, 0, 0, 3'd0, 32'h0);

    // back-to-back with waits
    xfer(1, 1, 16'h0000, 32'h01020304, 4'hF, 3, 0, 0, 1, 3'd0, 32'h01020304);
    xfer(1, 0, 16'h0000, 32'h0, 4'hF, 3, 32'h01020304, 0, 0, 3'd0, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 0, 32'(q0.size() + q1.size()), 32'h0);
    done = 1'b1;
  endtask

  initial begin
    bd_en = 1'b0; bd_d = 0; bd_i = '0; bd_v = '0;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; psel[d] = 1'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    #1;
    fork
      monitor();
      stim();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
- APB3/APB4 completer that converts bus transfers into the single-cycle register write port (`reg_apb_wen`/`wdata`/`addr`) of the 8-entry APB register file.
- Returns read data from the register file's R0..R7 outputs.
- Sits directly upstream of the register file, between the APB bridge/interconnect and that block.
- Adds programmable wait states, byte-strobe merging, address decode and error response.

Parameters:
- APB_ADDR_WIDTH, 16, width of PADDR.
- APB_DATA_WIDTH, 32, data width; must be 32 (byte strobes assume 4 lanes).
- REG_NUM, 8, number of registers; fixed at 8.
- BASE_ADDR, 16'h0000, byte address of R0; registers are word-spaced (R_i at BASE_ADDR + 4*i).
- WAIT_CYCLES, 0, wait states inserted in the access phase (0..15).
- RO_MASK, 8'h00, bit i = 1 makes R_i read-only from APB.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  1 = write.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte-lane strobes.
- PREADY  out  1  transfer complete.
- PRDATA  out  32  read data.
- PSLVERR  out  1  error response, valid only with PREADY.
- reg_apb_wen  out  1  one-cycle write strobe to the register file.
- reg_apb_wdata  out  32  merged write data.
- reg_apb_addr  out  3  register index.
- R0..R7  in  32 each  current register values from the register file.

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on posedge clk.
  - resetn low at a posedge puts state in IDLE and clears wait_cnt to 0; no asynchronous path.
  - Reset mid-transfer abandons the transfer with no write; the bus must re-issue it.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase). wait_cnt <= WAIT_CYCLES. Latch addr_q = PADDR and write_q = PWRITE.
  - ACCESS, wait_cnt != 0: wait_cnt decrements each cycle.
  - ACCESS, wait_cnt == 0: completion cycle -> IDLE.
  - ACCESS with PSEL=0 or PENABLE=0 (protocol violation): -> IDLE, no write, no response.
  - Back-to-back: the next setup phase arrives the cycle after completion and is accepted from IDLE. Peak throughput is one transfer per (2 + WAIT_CYCLES) cycles.
- PREADY = (state == ACCESS) & (wait_cnt == 0) & PSEL & PENABLE.
  - It is a function of registered state and live bus qualifiers only.
  - It is 0 in IDLE and 0 out of reset.
- Decode on addr_q:
  - off = addr_q - BASE_ADDR; idx = off[4:2]; off[1:0] are ignored.
  - err_addr = (addr_q < BASE_ADDR) or (off >= 32).
  - err_ro = write_q & RO_MASK[idx] & !err_addr.
  - PSLVERR = PREADY & (err_addr | err_ro); 0 at all other times.
- Write:
  - reg_apb_wen = PREADY & write_q & !PSLVERR & (PSTRB != 0).
  - It is high for exactly one cycle; the register file commits at that same clock edge.
- reg_apb_wdata, per byte lane b: PSTRB[b] ? PWDATA[8b+7:8b] : R_idx[8b+7:8b].
  - The merge uses the R_idx value sampled in the completion cycle.
  - PSTRB = 0 completes with PREADY and no write.
  - APB3 masters tie PSTRB to 4'hF.
- reg_apb_addr = idx at all times; it is meaningful only with reg_apb_wen.
- Read: PRDATA = R_idx when PREADY & !write_q & !err_addr, else 32'h0.
  - The read reflects register contents in the completion cycle.
  - Reads of read-only registers succeed.
- Simultaneous writes: a write from the other register-file writer in the same cycle is overridden by the APB write, since the register file gives APB priority.
- PWDATA and PSTRB are sampled only in the completion cycle; changes during wait states have no effect.

Test Plan:
- Write, WAIT_CYCLES=0: PADDR=16'h0008, PWDATA=32'hDEADBEEF, PSTRB=4'hF -> PREADY in the first access cycle; reg_apb_wen=1 for one cycle with addr=2, wdata=32'hDEADBEEF; PSLVERR=0.
- Byte strobe: R3=32'h11223344, write PADDR=16'h000C, PWDATA=32'hAABBCCDD, PSTRB=4'b0101 -> reg_apb_wdata=32'h11BB33DD, reg_apb_addr=3.
- Wait states, WAIT_CYCLES=3: read PADDR=16'h001C with R7=32'h00000077 -> PREADY low for 3 access cycles, high on the 4th with PRDATA=32'h00000077; PRDATA=0 in every other cycle.
- Errors, RO_MASK=8'h02:
  - Write PADDR=16'h0004 -> PSLVERR=1 with PREADY, reg_apb_wen never asserts.
  - Read PADDR=16'h0020 -> PSLVERR=1, PRDATA=0.
  - Read PADDR=16'h0004 -> PSLVERR=0, PRDATA=R1.
- Back-to-back and abort: write then read issued on consecutive setup phases -> both complete, with the read returning the new value. Dropping PSEL mid-wait -> FSM returns to IDLE, no reg_apb_wen.
- Reset mid-transfer: resetn=0 for one cycle during an ACCESS wait state -> next cycle state is IDLE, PREADY=0, no write issued; a subsequent transfer completes normally.
